// File: rtl/mips_alu_seq_if.sv
// ============================================================================
//  Module      : mips_alu_seq_if
//  Description : Operand/result handshake bundle for the registered MIPS ALU.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mips_alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [2:0]       sel;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output start, in0, in1, sel,
        input  ready, done, result, zero
    );

    modport slave (
        input  start, in0, in1, sel,
        output ready, done, result, zero
    );
endinterface

`default_nettype wire

// File: rtl/mips_alu_seq.sv
// ============================================================================
//  Module      : mips_alu_seq
//  Description : Registered MIPS ALU with single-cycle ops and a WIDTH-cycle
//                iterative shift-add multiply behind a start/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  wire logic     clock,
    input  wire logic     reset,
    mips_alu_seq_if.slave bus
);

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_SLT = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_AND = 3'd4;
    localparam logic [2:0] c_OP_SLL = 3'd5;
    localparam logic [2:0] c_OP_SRA = 3'd6;
    localparam logic [2:0] c_OP_MUL = 3'd7;

    localparam logic [SHAMT_W-1:0] c_CNT_LAST = SHAMT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state,  w_state_nxt;
    logic [WIDTH-1:0]   r_mcand,  w_mcand_nxt;
    logic [WIDTH-1:0]   r_mplier, w_mplier_nxt;
    logic [WIDTH-1:0]   r_acc,    w_acc_nxt;
    logic [SHAMT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic               r_zero,   w_zero_nxt;
    logic               r_done,   w_done_nxt;

    logic               w_accept;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_lt;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_acc_sum;

    assign w_accept  = bus.start && (r_state == S_IDLE);
    assign w_shamt   = bus.in1[SHAMT_W-1:0];
    assign w_lt      = $signed(bus.in0) < $signed(bus.in1);
    assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Single-cycle datapath; the MUL code is handled by the iterative engine.
    always_comb begin
        w_alu = '0;
        case (bus.sel)
            c_OP_ADD: w_alu = bus.in0 + bus.in1;
            c_OP_SUB: w_alu = bus.in0 - bus.in1;
            c_OP_SLT: w_alu = {{(WIDTH-1){1'b0}}, w_lt};
            c_OP_OR:  w_alu = bus.in0 | bus.in1;
            c_OP_AND: w_alu = bus.in0 & bus.in1;
            c_OP_SLL: w_alu = bus.in0 << w_shamt;
            c_OP_SRA: w_alu = $unsigned($signed(bus.in0) >>> w_shamt);
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_zero_nxt   = r_zero;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.sel == c_OP_MUL) begin
                        w_mcand_nxt  = bus.in0;
                        w_mplier_nxt = bus.in1;
                        w_acc_nxt    = '0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = S_BUSY;
                    end else begin
                        w_result_nxt = w_alu;
                        w_zero_nxt   = (w_alu == '0);
                        w_done_nxt   = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                w_acc_nxt    = w_acc_sum;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt + SHAMT_W'(1);
                // Last iteration: publish the sum including this step's partial product.
                if (r_cnt == c_CNT_LAST) begin
                    w_result_nxt = w_acc_sum;
                    w_zero_nxt   = (w_acc_sum == '0);
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_zero   <= w_zero_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign bus.ready  = (r_state == S_IDLE);
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.zero   = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_mips_alu_seq.sv
// ============================================================================
//  Module      : tb_mips_alu_seq
//  Description : Directed vector bench for mips_alu_seq (WIDTH=16).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_alu_seq;

    localparam int WIDTH = 16;

    logic clock;
    logic reset;

    mips_alu_seq_if #(.WIDTH(WIDTH)) bus ();

    mips_alu_seq #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]       sel;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             z;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues a MUL, optionally pulses start during BUSY, waits for done.
    task automatic do_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp, input bit poke);
        int  cyc;
        bit  ready_bad;
        bus.start = 1'b1; bus.sel = 3'd7; bus.in0 = a; bus.in1 = b;
        tick();
        bus.start = 1'b0;
        cyc = 0;
        ready_bad = 1'b0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.ready !== 1'b0) ready_bad = 1'b1;
            if (poke && cyc == 3) begin
                bus.start = 1'b1; bus.sel = 3'd0; bus.in0 = 16'h0009; bus.in1 = 16'h0009;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        chk("mul_latency", cyc, 16);
        chk("mul_ready_low_while_busy", {31'd0, ready_bad}, 0);
        chk("mul_result", bus.result, exp);
        chk("mul_zero", bus.zero, (exp == '0));
        chk("mul_ready_at_done", bus.ready, 1);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 16'h0004, 16'h0003, 16'h0007, 1'b0}; // ADD
        vecs[1]  = '{3'd1, 16'h0003, 16'h0003, 16'h0000, 1'b1}; // SUB
        vecs[2]  = '{3'd1, 16'h0003, 16'h0004, 16'hFFFF, 1'b0};
        vecs[3]  = '{3'd2, 16'hFFFE, 16'h0003, 16'h0001, 1'b0}; // SLT signed
        vecs[4]  = '{3'd2, 16'h0004, 16'h0003, 16'h0000, 1'b1};
        vecs[5]  = '{3'd3, 16'h0004, 16'h0003, 16'h0007, 1'b0}; // OR
        vecs[6]  = '{3'd4, 16'h0004, 16'h0007, 16'h0004, 1'b0}; // AND
        vecs[7]  = '{3'd5, 16'h0001, 16'h0013, 16'h0008, 1'b0}; // SLL low 4 bits
        vecs[8]  = '{3'd6, 16'h8000, 16'h0004, 16'hF800, 1'b0}; // SRA
        vecs[9]  = '{3'd6, 16'h4000, 16'h000F, 16'h0000, 1'b1};
        vecs[10] = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1}; // ADD wrap
        vecs[11] = '{3'd2, 16'h0003, 16'hFFFE, 16'h0000, 1'b1};
        vecs[12] = '{3'd0, 16'h1234, 16'h0001, 16'h1235, 1'b0};

        reset = 1'b1;
        bus.start = 1'b0; bus.sel = 3'd0; bus.in0 = '0; bus.in1 = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", bus.ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_zero", bus.zero, 1);

        // Back-to-back single-cycle ops with start held high.
        for (int i = 0; i < NV; i++) begin
            bus.start = 1'b1; bus.sel = vecs[i].sel; bus.in0 = vecs[i].a; bus.in1 = vecs[i].b;
            tick();
            chk($sformatf("vec%0d_done", i), bus.done, 1);
            chk($sformatf("vec%0d_result", i), bus.result, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), bus.zero, vecs[i].z);
        end
        bus.start = 1'b0;
        tick();
        chk("done_drops", bus.done, 0);
        chk("result_held", bus.result, 16'h1235);

        // MUL with an ignored start pulse during BUSY.
        do_mul(16'h0007, 16'h0003, 16'h0015, 1'b1);
        tick();
        chk("mul_done_one_cycle", bus.done, 0);
        chk("busy_start_ignored", bus.result, 16'h0015);
        chk("busy_start_not_queued", bus.ready, 1);

        do_mul(16'h0100, 16'h0100, 16'h0000, 1'b0);
        tick();

        // Make result non-zero so the reset clear is visible.
        bus.start = 1'b1; bus.sel = 3'd0; bus.in0 = 16'h0001; bus.in1 = 16'h0002;
        tick();
        bus.start = 1'b0;
        chk("pre_abort_result", bus.result, 16'h0003);

        // Abort a multiply with reset on its 5th BUSY cycle.
        bus.start = 1'b1; bus.sel = 3'd7; bus.in0 = 16'h00FF; bus.in1 = 16'h00FF;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_still_busy", bus.ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_ready", bus.ready, 1);
        chk("abort_result", bus.result, 0);
        chk("abort_zero", bus.zero, 1);
        begin
            bit saw_done;
            saw_done = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (bus.done !== 1'b0) saw_done = 1'b1;
                tick();
            end
            chk("abort_no_done", {31'd0, saw_done}, 0);
        end

        // Accept ADD in the same cycle the MUL done pulse is high.
        do_mul(16'h0005, 16'h0005, 16'h0019, 1'b0);
        bus.start = 1'b1; bus.sel = 3'd0; bus.in0 = 16'h0001; bus.in1 = 16'h0001;
        tick();
        bus.start = 1'b0;
        chk("b2b_done", bus.done, 1);
        chk("b2b_result", bus.result, 16'h0002);
        chk("b2b_zero", bus.zero, 0);
        tick();
        chk("b2b_done_drops", bus.done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_alu_seq.md
Name: mips_alu_seq

Overview:
Parametrised, registered successor to the 16-bit combinational MIPS ALU. It keeps the five base ops (ADD, SUB, SLT, OR, AND) and adds SLL, SRA and an iterative shift-add multiply. Operands are captured through a start/ready handshake, and the result is registered with a one-cycle done pulse. It sits between the register-file read muxes and the writeback mux, and the multi-cycle control stalls on ready.

Parameters:
WIDTH, 16, datapath width in bits (>=4, power of 2)
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from in1

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
start  input  1  request; accepted on an edge where start=1 and ready=1
in0  input  WIDTH  operand A, sampled on accept edge only
in1  input  WIDTH  operand B, sampled on accept edge only
sel  input  3  op: 0 ADD, 1 SUB, 2 SLT, 3 OR, 4 AND, 5 SLL, 6 SRA, 7 MUL
ready  output  1  1 = idle, can accept
done  output  1  one-cycle pulse: result updated on the previous edge
result  output  WIDTH  last completed result, held until the next completion
zero  output  1  1 iff result==0, registered together with result

Behaviour:
- Reset (sync, wins over everything): state=IDLE, ready=1, done=0, result=0, zero=1, multiply counter and accumulators cleared.
- Reset during BUSY: the multiply is aborted and no done pulse is produced.
- States:
  - IDLE (ready=1): on accept with sel 0-6, compute combinationally from in0/in1, register result/zero, done=1 next cycle, stay IDLE. Latency is 1 edge.
  - IDLE, accept with sel=7: load multiplicand=in0, multiplier=in1, acc=0, cnt=0; go to BUSY with ready=0.
  - BUSY: each edge, if multiplier[0] then acc+=multiplicand; multiplicand<<=1; multiplier>>=1; cnt++. On the WIDTH-th BUSY edge, write result=final acc and zero, set done=1, ready=1, return to IDLE.
  - MUL done rises exactly WIDTH edges after the accept edge, and ready stays low for WIDTH cycles.
- done is high for exactly one cycle per completed op and is otherwise 0. result/zero do not change except at completion or reset.
- start while ready=0 is ignored, not queued. in0/in1/sel changes during BUSY have no effect.
- start in the cycle where done=1 (IDLE) is accepted normally, which allows back-to-back single-cycle ops every cycle.
- Arithmetic:
  - ADD, SUB and MUL wrap modulo 2^WIDTH. MUL returns the low WIDTH bits. There are no overflow flags.
  - SLT is signed two's-complement: result = {WIDTH-1 zeros, in0<in1}.
  - SLL and SRA shift in0 by in1[SHAMT_W-1:0]; upper in1 bits are ignored. SRA replicates in0[WIDTH-1].
  - OR and AND are bitwise.
- No X on outputs after reset; sel is fully decoded, with no unused codes.

Test Plan:
1. WIDTH=16. Reset 2 cycles. Check ready=1, done=0, result=0, zero=1. Then ADD in0=4, in1=3 -> next cycle done=1, result=0x0007, zero=0; done=0 the cycle after.
2. Back-to-back ops with start held high: SUB 3,3 -> 0x0000 zero=1; SUB 3,4 -> 0xFFFF; SLT 0xFFFE,3 -> 0x0001; SLT 4,3 -> 0x0000; OR 4,3 -> 0x0007; AND 4,7 -> 0x0004. Each result and done pulse lands one cycle after its start.
3. SLL in0=0x0001, in1=0x0013 -> 0x0008 (low 4 bits used). SRA 0x8000 by 4 -> 0xF800. SRA 0x4000 by 15 -> 0x0000, zero=1.
4. MUL 7*3 -> ready low for 16 cycles, done exactly 16 edges after accept, result=0x0015. Pulse start with other operands during BUSY -> ignored, result unchanged. Then MUL 0x0100*0x0100 -> 0x0000, zero=1 (wrap).
5. Start MUL 0x00FF*0x00FF, assert reset on the 5th BUSY cycle -> next cycle ready=1, result=0, zero=1, and no done pulse for 20 cycles.
6. Accept ADD 1,1 in the same cycle MUL done=1 -> the MUL result is visible for one cycle, then 0x0002 with a second done pulse.
